// File: rtl/uart_rx_if.sv
// ----------------------------------------------------------------------------
// uart_rx_if
//   Bundles the serial line input and the received-byte outputs of uart_rx.
//
//   Signals:
//     rx_in       serial line, idle high (driven by the line side)
//     data_out    last correctly framed byte
//     valid       one-cycle pulse, new byte on data_out
//     frame_err   one-cycle pulse, stop bit sampled low
//     busy        receiver is inside a frame
//     parity_err  one-cycle pulse, parity mismatch (only with URX_PARITY_EN)
//
//   Modports:
//     slave   the receiver (uart_rx)
//     master  the line driver / byte consumer side
//
//   Optional feature macro: URX_PARITY_EN
// ----------------------------------------------------------------------------
interface uart_rx_if;
    logic       rx_in;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       busy;
`ifdef URX_PARITY_EN
    logic       parity_err;

    modport slave (
        input  rx_in,
        output data_out,
        output valid,
        output frame_err,
        output busy,
        output parity_err
    );

    modport master (
        output rx_in,
        input  data_out,
        input  valid,
        input  frame_err,
        input  busy,
        input  parity_err
    );
`else
    modport slave (
        input  rx_in,
        output data_out,
        output valid,
        output frame_err,
        output busy
    );

    modport master (
        output rx_in,
        input  data_out,
        input  valid,
        input  frame_err,
        input  busy
    );
`endif
endinterface

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver with 16x oversampling, 2-FF input synchronizer,
//   false-start rejection, 3-sample majority vote and stop-bit check.
//   With URX_PARITY_EN defined the frame becomes 8E1 and a parity_err
//   pulse is added.
//
//   Parameters:
//     CLK_HZ  system clock frequency in Hz
//     BAUD    line rate; prescaler DIV = (CLK_HZ/BAUD) >> 4
//
//   Ports:
//     clk     system clock, all logic on posedge
//     rst_n   synchronous active-low reset
//     bus     uart_rx_if.slave: rx_in in; data_out, valid, frame_err,
//             busy (and parity_err) out
//
//   Optional feature macro: URX_PARITY_EN
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int unsigned CLK_HZ = 32'd50000000,
    parameter int unsigned BAUD   = 32'd9600
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.slave bus
);

    localparam logic [8:0] DIV = 9'((CLK_HZ / BAUD) >> 4);

`ifdef URX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
    } state_t;
`endif

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

`ifdef URX_PARITY_EN
    function automatic logic even_par(input logic [7:0] v);
        return ^v;
    endfunction
`endif

    // synchronizer, edge-detect history and start-detect arming
    logic       rx_meta_q;
    logic       rx_s_q;
    logic       rx_d_q;
    logic [2:0] arm_q;

    state_t     state_q,   state_d;
    logic [8:0] pc_q,      pc_d;
    logic [3:0] sc_q,      sc_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] sr_q,      sr_d;
    logic       smp7_q,    smp7_d;
    logic       smp8_q,    smp8_d;
    logic [7:0] data_q,    data_d;
    logic       valid_q,   valid_d;
    logic       ferr_q,    ferr_d;
    logic       busy_q,    busy_d;
`ifdef URX_PARITY_EN
    logic       par_bad_q, par_bad_d;
    logic       perr_q,    perr_d;
`endif

    logic tick_s;
    logic samp9_s;
    logic wrap_s;
    logic maj_s;
    logic fall_s;

    assign tick_s  = (pc_q == DIV);
    assign samp9_s = tick_s && (sc_q == 4'd8);
    assign wrap_s  = tick_s && (sc_q == 4'd15);
    // third sample is taken live on the tick where sc becomes 9
    assign maj_s   = maj3(smp7_q, smp8_q, rx_s_q);
    // rx_d only counts as a real "high" once the synchronizer holds line
    // samples rather than reset values, so a line that is already low when
    // reset releases is not mistaken for a start edge
    assign fall_s  = arm_q[2] && rx_d_q && !rx_s_q;

    // input synchronizer and edge history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
            arm_q     <= 3'b000;
        end else begin
            rx_meta_q <= bus.rx_in;
            rx_s_q    <= rx_meta_q;
            rx_d_q    <= rx_s_q;
            arm_q     <= {arm_q[1:0], 1'b1};
        end
    end

    // next-state, counters, sampling and output decisions
    always_comb begin
        state_d   = state_q;
        pc_d      = tick_s ? 9'd0 : (pc_q + 9'd1);
        sc_d      = tick_s ? (sc_q + 4'd1) : sc_q;
        bit_idx_d = bit_idx_q;
        sr_d      = sr_q;
        smp7_d    = (tick_s && (sc_q == 4'd6)) ? rx_s_q : smp7_q;
        smp8_d    = (tick_s && (sc_q == 4'd7)) ? rx_s_q : smp8_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef URX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                pc_d = 9'd0;
                sc_d = 4'd0;
                if (fall_s) begin
                    state_d   = S_START;
                    bit_idx_d = 3'd0;
`ifdef URX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_START: begin
                if (samp9_s && maj_s) begin
                    state_d = S_IDLE;       // glitch, not a real start bit
                end else if (wrap_s) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_START;
                end
            end

            S_DATA: begin
                if (samp9_s) begin
                    sr_d = {maj_s, sr_q[7:1]};   // LSB arrives first
                end else begin
                    sr_d = sr_q;
                end
                if (wrap_s) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef URX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    bit_idx_d = bit_idx_q;
                end
            end

`ifdef URX_PARITY_EN
            S_PARITY: begin
                if (samp9_s) begin
                    par_bad_d = (maj_s != even_par(sr_q));
                end else begin
                    par_bad_d = par_bad_q;
                end
                if (wrap_s) begin
                    state_d = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
`endif

            S_STOP: begin
                // decide mid-stop-bit so a back-to-back start edge is seen
                if (samp9_s) begin
                    state_d = S_IDLE;
                    if (!maj_s) begin
                        ferr_d = 1'b1;
`ifdef URX_PARITY_EN
                    end else if (par_bad_q) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        valid_d = 1'b1;
                        data_d  = sr_q;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= 9'd0;
            sc_q      <= 4'd0;
            bit_idx_q <= 3'd0;
            sr_q      <= 8'd0;
            smp7_q    <= 1'b1;
            smp8_q    <= 1'b1;
            data_q    <= 8'd0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef URX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            sc_q      <= sc_d;
            bit_idx_q <= bit_idx_d;
            sr_q      <= sr_d;
            smp7_q    <= smp7_d;
            smp8_q    <= smp8_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
`ifdef URX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = busy_q;
`ifdef URX_PARITY_EN
    assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
//   Self-checking bench for uart_rx. Runs the receiver at a scaled-down
//   line rate (DIV = 4, 80 clocks per bit) so whole frames stay short.
//   Frames are driven bit by bit; expectations come from a table and from a
//   small frame-level model (byte, stop bit, parity -> pulse kind, data_out,
//   fixed tick-count latency).
// ----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CLK_HZ = 640000;
    localparam int BAUD   = 10000;
    localparam int DIV    = (CLK_HZ / BAUD) >> 4;
    localparam int TICK   = DIV + 1;
    localparam int BIT    = TICK * 16;
`ifdef URX_PARITY_EN
    localparam int FBITS  = 11;
    localparam int LAT    = 169 * TICK + 2;
    localparam int NV     = 8;
`else
    localparam int FBITS  = 10;
    localparam int LAT    = 153 * TICK + 2;
    localparam int NV     = 6;
`endif

    logic clk;
    logic rst_n;
    uart_rx_if bus();

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // event monitor
    int         n_valid = 0, n_ferr = 0, n_perr = 0, n_both = 0, n_dglitch = 0;
    int         last_ev_cyc = 0;
    logic [7:0] prev_data = 8'h00;
    logic       rst_seen = 1'b1;
    logic       perr_s;

`ifdef URX_PARITY_EN
    assign perr_s = bus.parity_err;
`else
    assign perr_s = 1'b0;
`endif

    always @(negedge clk) begin
        if (bus.valid)     begin n_valid++; last_ev_cyc = cyc; end
        if (bus.frame_err) begin n_ferr++;  last_ev_cyc = cyc; end
        if (perr_s)        begin n_perr++;  last_ev_cyc = cyc; end
        if (int'(bus.valid) + int'(bus.frame_err) + int'(perr_s) > 1) n_both++;
        if ((bus.valid || bus.frame_err || perr_s) && !rst_n) n_both++;
        if (bus.data_out !== prev_data && !bus.valid && !rst_seen) n_dglitch++;
        prev_data = bus.data_out;
        rst_seen  = !rst_n;
    end

    int n_total = 0;
    int n_pass  = 0;
    int fall_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_total++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic idle(input int n);
        bus.rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // drive one frame; rst_pos >= 0 pulses rst_n mid-way through that bit
    task automatic send_frame(input logic [7:0] d, input logic stop_ok,
                              input logic par_flip, input int rst_pos);
        logic [10:0] bits;
`ifdef URX_PARITY_EN
        bits = {stop_ok, (^d) ^ par_flip, d, 1'b0};
`else
        bits = {1'b0, stop_ok, d, 1'b0};
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        fall_cyc = cyc;
        for (int p = 0; p < FBITS; p++) begin
            bus.rx_in = bits[p];
            for (int c = 0; c < BIT; c++) begin
                rst_n = !(p == rst_pos && c == BIT / 2);
                @(posedge clk);
                #1;
                if (p == rst_pos && c == BIT / 2) begin
                    check("reset_busy", int'(bus.busy), 0);
                    check("reset_valid", int'(bus.valid), 0);
                end
            end
        end
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       par_flip;
        logic       exp_valid;
        logic       exp_ferr;
        logic       exp_perr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tv [NV];

    initial begin
        int bv, bf, bp, t1, t2;
        logic [7:0] model_data;
        logic [7:0] d;
        logic       ok, pf;

        tv[0] = '{8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55};
        tv[1] = '{8'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA3};
        tv[2] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tv[3] = '{8'hC4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tv[4] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF};
        tv[5] = '{8'h7E, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7E};
`ifdef URX_PARITY_EN
        tv[6] = '{8'h0F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0F};
        tv[7] = '{8'h0F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0F};
`endif

        // reset state
        rst_n     = 1'b0;
        bus.rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", int'(bus.data_out), 0);
        check("rst_valid", int'(bus.valid), 0);
        check("rst_frame_err", int'(bus.frame_err), 0);
        check("rst_busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        idle(8);

        // table-driven frames
        for (int i = 0; i < NV; i++) begin
            bv = n_valid; bf = n_ferr; bp = n_perr;
            send_frame(tv[i].data, tv[i].stop_ok, tv[i].par_flip, -1);
            check($sformatf("vec%0d_valid", i), n_valid - bv, int'(tv[i].exp_valid));
            check($sformatf("vec%0d_ferr", i), n_ferr - bf, int'(tv[i].exp_ferr));
            check($sformatf("vec%0d_perr", i), n_perr - bp, int'(tv[i].exp_perr));
            check($sformatf("vec%0d_data", i), int'(bus.data_out), int'(tv[i].exp_data));
            check_rng($sformatf("vec%0d_latency", i), last_ev_cyc - fall_cyc, LAT - 2, LAT + 2);
            idle(2 * BIT);
            check($sformatf("vec%0d_busy_after", i), int'(bus.busy), 0);
        end

        // back-to-back frames with no idle gap
        bv = n_valid;
        send_frame(8'hA3, 1'b1, 1'b0, -1);
        t1 = last_ev_cyc;
        check("b2b_first_data", int'(bus.data_out), 8'hA3);
        send_frame(8'h00, 1'b1, 1'b0, -1);
        t2 = last_ev_cyc;
        check("b2b_second_data", int'(bus.data_out), 8'h00);
        check("b2b_valid_count", n_valid - bv, 2);
        check_rng("b2b_spacing", t2 - t1, FBITS * BIT - 4, FBITS * BIT + 4);
        idle(BIT);

        // short low glitch: busy pulses, nothing is delivered
        bv = n_valid; bf = n_ferr; bp = n_perr;
        bus.rx_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("glitch_busy_high", int'(bus.busy), 1);
        repeat (4) @(posedge clk);
        #1;
        idle(3 * BIT);
        check("glitch_busy_low", int'(bus.busy), 0);
        check("glitch_no_pulses", (n_valid - bv) + (n_ferr - bf) + (n_perr - bp), 0);
        send_frame(8'h7E, 1'b1, 1'b0, -1);
        check("glitch_next_valid", n_valid - bv, 1);
        check("glitch_next_data", int'(bus.data_out), 8'h7E);
        idle(BIT);

        // reset during data bit 4 of 0x81 (frame position 5)
        bv = n_valid; bf = n_ferr; bp = n_perr;
        send_frame(8'h81, 1'b1, 1'b0, 5);
        idle(2 * BIT);
        check("midrst_no_pulses", (n_valid - bv) + (n_ferr - bf) + (n_perr - bp), 0);
        check("midrst_data_cleared", int'(bus.data_out), 0);
        check("midrst_busy", int'(bus.busy), 0);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        check("midrst_next_valid", n_valid - bv, 1);
        check("midrst_next_data", int'(bus.data_out), 8'h3C);
        idle(BIT);

        // randomized frames against the frame-level model
        model_data = 8'h3C;
        for (int k = 0; k < 12; k++) begin
            d  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
`ifdef URX_PARITY_EN
            pf = ($urandom_range(0, 3) == 0);
`else
            pf = 1'b0;
`endif
            bv = n_valid; bf = n_ferr; bp = n_perr;
            send_frame(d, ok, pf, -1);
            if (ok && !pf) model_data = d;
            check($sformatf("rnd%0d_valid", k), n_valid - bv, int'(ok && !pf));
            check($sformatf("rnd%0d_ferr", k), n_ferr - bf, int'(!ok));
            check($sformatf("rnd%0d_perr", k), n_perr - bp, int'(ok && pf));
            check($sformatf("rnd%0d_data", k), int'(bus.data_out), int'(model_data));
            check_rng($sformatf("rnd%0d_latency", k), last_ev_cyc - fall_cyc, LAT - 2, LAT + 2);
            if (!ok) idle(2 * BIT);
            else     idle($urandom_range(0, 20));
        end
        idle(2 * BIT);

        check("pulses_exclusive", n_both, 0);
        check("data_only_with_valid", n_dglitch, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
